// File: rtl/mem_l2_arb_if.sv
// mem_l2_arb_if: requester A/B tile ports and the single L2 tile request port.
// slave = arbiter view, master = requesters/L2 environment view.
interface mem_l2_arb_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 128
);
   logic [ADDR_W-1:0] aMemAddr;
   logic [4:0]        aMemOpm;
   logic [DATA_W-1:0] aMemDataIn;
   logic [DATA_W-1:0] aMemDataOut;
   logic [1:0]        aMemOK;

   logic [ADDR_W-1:0] bMemAddr;
   logic [4:0]        bMemOpm;
   logic [DATA_W-1:0] bMemDataIn;
   logic [DATA_W-1:0] bMemDataOut;
   logic [1:0]        bMemOK;

   logic [ADDR_W-1:0] l2MemAddr;
   logic [4:0]        l2MemOpm;
   logic [DATA_W-1:0] l2MemDataOut;
   logic [DATA_W-1:0] l2MemDataIn;
   logic [1:0]        l2MemOK;

   modport slave (
      input  aMemAddr, aMemOpm, aMemDataIn,
      output aMemDataOut, aMemOK,
      input  bMemAddr, bMemOpm, bMemDataIn,
      output bMemDataOut, bMemOK,
      output l2MemAddr, l2MemOpm, l2MemDataOut,
      input  l2MemDataIn, l2MemOK
   );

   modport master (
      output aMemAddr, aMemOpm, aMemDataIn,
      input  aMemDataOut, aMemOK,
      output bMemAddr, bMemOpm, bMemDataIn,
      input  bMemDataOut, bMemOK,
      input  l2MemAddr, l2MemOpm, l2MemDataOut,
      output l2MemDataIn, l2MemOK
   );
endinterface

// File: rtl/mem_l2_arb.sv
// mem_l2_arb: merges the I-cache (A) and D-cache (B) tile ports onto one registered L2 request port.
// Define MEM_L2_ARB_RR_EN for strict alternation under contention; default is fixed B priority.
module mem_l2_arb #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 128
) (
   input  logic        clock,
   input  logic        reset,
   mem_l2_arb_if.slave bus
);

   localparam logic [4:0] UMEM_OPM_READY = 5'h00;
   localparam logic [1:0] UMEM_OK_READY  = 2'd0;
   localparam logic [1:0] UMEM_OK_OK     = 2'd1;
   localparam logic [1:0] UMEM_OK_HOLD   = 2'd2;
   localparam logic [1:0] UMEM_OK_FAULT  = 2'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
   typedef enum logic {PORT_A, PORT_B} port_t;

   state_t            r_state;
   state_t            w_nextState;
   port_t             r_grant;
   port_t             w_winner;
   port_t             w_contendWin;
   logic [ADDR_W-1:0] r_l2Addr;
   logic [4:0]        r_l2Opm;
   logic [DATA_W-1:0] r_l2Data;
   logic [1:0]        r_final;
   logic              r_dropped;
   logic              w_aAct;
   logic              w_bAct;
   logic              w_gAct;
   logic              w_l2Fin;
   logic [1:0]        w_gOk;
   logic [1:0]        w_aOk;
   logic [1:0]        w_bOk;

   assign w_aAct  = (bus.aMemOpm[4:3] != 2'b00);
   assign w_bAct  = (bus.bMemOpm[4:3] != 2'b00);
   assign w_gAct  = (r_grant == PORT_A) ? w_aAct : w_bAct;
   assign w_l2Fin = (bus.l2MemOK == UMEM_OK_OK) || (bus.l2MemOK == UMEM_OK_FAULT);

`ifdef MEM_L2_ARB_RR_EN
   port_t r_rrLast;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_rrLast <= PORT_A;
      end else if ((r_state == ST_DONE) && (w_nextState == ST_IDLE)) begin
         r_rrLast <= r_grant;
      end
   end

   assign w_contendWin = (r_rrLast == PORT_A) ? PORT_B : PORT_A;
`else
   assign w_contendWin = PORT_B;
`endif

   assign w_winner = (w_aAct && w_bAct) ? w_contendWin : (w_aAct ? PORT_A : PORT_B);

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: if (w_aAct || w_bAct) w_nextState = ST_BUSY;
         ST_BUSY: if (w_l2Fin) w_nextState = ST_DONE;
         ST_DONE: if (!w_gAct && (bus.l2MemOK == UMEM_OK_READY)) w_nextState = ST_IDLE;
         default: w_nextState = ST_IDLE;
      endcase
   end

   // r_dropped keeps a re-raised request from the granted port on HOLD until re-arbitrated
   always_comb begin
      w_gOk = UMEM_OK_HOLD;
      case (r_state)
         ST_BUSY: if (bus.l2MemOK != UMEM_OK_READY) w_gOk = bus.l2MemOK;
         ST_DONE: if (!r_dropped) w_gOk = r_final;
         default: w_gOk = UMEM_OK_HOLD;
      endcase
      w_aOk = UMEM_OK_READY;
      if (w_aAct) begin
         w_aOk = ((r_state != ST_IDLE) && (r_grant == PORT_A)) ? w_gOk : UMEM_OK_HOLD;
      end
      w_bOk = UMEM_OK_READY;
      if (w_bAct) begin
         w_bOk = ((r_state != ST_IDLE) && (r_grant == PORT_B)) ? w_gOk : UMEM_OK_HOLD;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_grant   <= PORT_B;
         r_l2Addr  <= '0;
         r_l2Opm   <= UMEM_OPM_READY;
         r_l2Data  <= '0;
         r_final   <= UMEM_OK_READY;
         r_dropped <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_aAct || w_bAct) begin
                  r_grant   <= w_winner;
                  r_dropped <= 1'b0;
                  if (w_winner == PORT_A) begin
                     r_l2Addr <= bus.aMemAddr;
                     r_l2Opm  <= bus.aMemOpm;
                     r_l2Data <= bus.aMemDataIn;
                  end else begin
                     r_l2Addr <= bus.bMemAddr;
                     r_l2Opm  <= bus.bMemOpm;
                     r_l2Data <= bus.bMemDataIn;
                  end
               end
            end
            ST_BUSY: begin
               if (w_l2Fin) begin
                  r_l2Opm <= UMEM_OPM_READY;
                  r_final <= bus.l2MemOK;
               end
            end
            ST_DONE: begin
               if (!w_gAct) r_dropped <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.aMemOK       = w_aOk;
   assign bus.bMemOK       = w_bOk;
   assign bus.aMemDataOut  = bus.l2MemDataIn;
   assign bus.bMemDataOut  = bus.l2MemDataIn;
   assign bus.l2MemAddr    = r_l2Addr;
   assign bus.l2MemOpm     = r_l2Opm;
   assign bus.l2MemDataOut = r_l2Data;

endmodule
